// File: rtl/fft_input_buffer.sv
// FFT front-end frame buffer: captures a 256-sample serial frame, then drains it as 32 beats of
// eight packed operands. Define FFT_IN_BITREV_EN to store samples at bit-reversed addresses.
module fft_input_buffer #(
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startin_i,
  input  logic signed [DW-1:0] realin_i,
  input  logic signed [DW-1:0] imagin_i,
  input  logic                 fft_ready_i,
  output logic [55:0]          in0_o,
  output logic [55:0]          in1_o,
  output logic [55:0]          in2_o,
  output logic [55:0]          in3_o,
  output logic [55:0]          in4_o,
  output logic [55:0]          in5_o,
  output logic [55:0]          in6_o,
  output logic [55:0]          in7_o,
  output logic                 load_valid_o,
  output logic [4:0]           beat_o,
  output logic                 start_fft_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  typedef enum logic [1:0] {StIdle, StFill, StFull, StDrain} state_e;

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [4:0]  beat_q, beat_d;
  logic        overrun_q, overrun_d;
  logic [55:0] lane_q [8];
  logic [55:0] mem_q [256];

  logic        wr_en;
  logic [7:0]  wr_addr;
  logic        ld_en;

  // Sign-extend to 26 bits and append two guard LSBs.
  function automatic logic [27:0] to_field(input logic [DW-1:0] s);
    return {{(26-DW){s[DW-1]}}, s, 2'b00};
  endfunction

`ifdef FFT_IN_BITREV_EN
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = count_q[7-i];
    end
  end
`else
  assign wr_addr = count_q;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 8'd0;
      beat_q    <= 5'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    beat_d    = beat_q;
    wr_en     = 1'b0;
    ld_en     = 1'b0;
    overrun_d = startin_i && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (startin_i) begin
          wr_en   = 1'b1;
          count_d = 8'd1;
          state_d = StFill;
        end
      end
      StFill: begin
        wr_en   = 1'b1;
        count_d = count_q + 8'd1;
        if (count_q == 8'd255) state_d = StFull;
      end
      StFull: begin
        if (fft_ready_i) begin
          state_d = StDrain;
          beat_d  = 5'd0;
          ld_en   = 1'b1;
        end
      end
      StDrain: begin
        if (beat_q == 5'd31) begin
          state_d = StIdle;
          beat_d  = 5'd0;
        end else begin
          beat_d = beat_q + 5'd1;
          ld_en  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {to_field(imagin_i), to_field(realin_i)};
  end

  // Operand lanes are loaded one edge ahead of the beat they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '{default: '0};
    end else if (ld_en) begin
      for (int j = 0; j < 8; j++) begin
        lane_q[j] <= mem_q[{beat_d, j[2:0]}];
      end
    end
  end

  // Outputs
  always_comb begin
    busy_o       = (state_q != StIdle);
    load_valid_o = (state_q == StDrain);
    start_fft_o  = (state_q == StDrain) && (beat_q == 5'd0);
    beat_o       = beat_q;
    overrun_o    = overrun_q;
    in0_o        = lane_q[0];
    in1_o        = lane_q[1];
    in2_o        = lane_q[2];
    in3_o        = lane_q[3];
    in4_o        = lane_q[4];
    in5_o        = lane_q[5];
    in6_o        = lane_q[6];
    in7_o        = lane_q[7];
  end

endmodule

// File: doc/fft_input_buffer.md
# fft_input_buffer

Front-end buffer of the 256-point FFT that feeds the butterfly array. It accepts one complex sample per cycle from the serial input stream and stores a full 256-sample frame. Once the core signals ready, it presents the frame as 32 beats of eight packed 56-bit operands, in the same lane packing the output buffer consumes at stage 7. It is the write-side counterpart to the output buffer's serial readout.

## Interface
- DW, 16, signed input sample width per component; legal range 8..24.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- startin  in  1  frame start; high in the cycle carrying sample 0.
- realin  in  DW  signed real part of the current sample.
- imagin  in  DW  signed imaginary part of the current sample.
- fft_ready  in  1  core idle and able to accept a 32-beat load.
- in0..in7  out  56 each  packed operands, lane j = sample 8*beat+j. Real part is in [27:0]; imaginary part is in [55:28].
- load_valid  out  1  in0..in7 and beat are valid this cycle.
- beat  out  5  load beat index, 0..31.
- start_fft  out  1  one-cycle pulse coincident with beat 0.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  one-cycle pulse when a startin is rejected.

## Operation
- Storage: 256 x 56-bit array, with the real and imaginary fields held side by side. The array is not cleared by reset.
- Field format: each 28-bit field is the sign extension of the sample followed by 2'b00, i.e. {{(26-DW){s[DW-1]}}, s, 2'b00}. The two LSB guard bits match the 2 LSBs the output buffer discards.
- Write address: a 0..255 sample counter, mapped through the Configuration option.
- Four-state FSM:
  - IDLE: startin=1 writes sample 0 at count 0, sets count to 1 and moves to FILL. startin=0 does nothing.
  - FILL: every cycle writes the current sample at count and increments count. realin/imagin are sampled unconditionally, with no gaps allowed. When sample 255 is written, count wraps to 0 and the FSM moves to FULL.
  - FULL: holds the frame. When fft_ready=1, the FSM moves to DRAIN with beat=0.
  - DRAIN: drives a registered beat each cycle, lane j = mem[8*beat+j], with load_valid=1. beat increments each cycle. After beat 31 the FSM returns to IDLE.
- Rejection:
  - startin=1 in FILL, FULL or DRAIN is ignored and produces an overrun pulse on the next cycle.
  - In FILL, the sample in that cycle is still written as a normal stream sample.
- Both the samples and fft_ready are sampled only in the states listed above. fft_ready is not examined during DRAIN.

## Timing
- Reset values:
  - FSM=IDLE, count=0, beat=0.
  - in0..in7=0, load_valid=0, start_fft=0, busy=0, overrun=0.
- Reset mid-frame or mid-drain aborts immediately, with no partial drain. Outputs return to reset values asynchronously.
- Fill latency: the edge of the startin cycle is write 0; the edge 255 cycles later is write 255 and the FSM enters FULL.
- Load timing:
  - In the first cycle in FULL with fft_ready=1, that edge registers beat 0.
  - load_valid and start_fft are high in the following cycle.
  - The beat 0 data is stable for exactly one cycle per beat.
- load_valid stays high for exactly 32 consecutive cycles. start_fft is high only for beat 0.
- Earliest next frame:
  - busy is still high in the beat-31 cycle, so a startin there is rejected.
  - busy drops the cycle after beat 31; a startin in that cycle is accepted.
  - The minimum frame period is therefore 256 + 1 + 32 cycles.
- Minimum frame-to-first-beat latency, with fft_ready already high: startin at cycle 0 puts beat 0 on the outputs at cycle 257.

## Configuration
- FFT_IN_BITREV_EN defined:
  - Sample n is written at address bitrev8(n).
  - The drain therefore delivers a bit-reversed frame, for the decimation-in-time core.
- FFT_IN_BITREV_EN undefined:
  - Sample n is written at address n.
  - The drain delivers natural order; the core then consumes the frame DIF-style.
- No other behaviour differs between the two settings.

## Test plan
- Ramp: realin=n, imagin=-n for n=0..255, macro off, fft_ready=1.
  - Beat 3, lane 5 carries real field 29<<2 and imaginary field sign-extended (-29)<<2.
  - start_fft pulses only with beat 0, and load_valid is high for exactly 32 cycles.
- Bitrev: the same ramp with FFT_IN_BITREV_EN defined.
  - Beat 0, lane 1 is sample 128; beat 31, lane 7 is sample 255.
- Backpressure: hold fft_ready=0 for 100 cycles after the fill.
  - busy=1 and load_valid=0 throughout.
  - The drain starts exactly one cycle after fft_ready rises.
- Extremes: DW=16, samples 0x7FFF and 0x8000.
  - Fields are 0x001FFFC and 0xFFE0000.
- Overrun: startin pulsed at fill sample 100 and again during beat 10.
  - Two overrun pulses; the frame data is unaltered and the drain still completes 32 beats.
- Reset at fill sample 50, then a clean frame.
  - All outputs are zero immediately.
  - The next startin begins at count 0, and the drain matches the new frame only.
